// File: rtl/apb3_slave_pkg.sv
// Shared types and helpers for the APB3 register-file slave.
package apb3_slave_pkg;

  localparam int MAX_WAIT = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of byte-offset bits below the register index.
  function automatic int calc_index_lsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/apb3_reg_bank.sv
// Register storage with a single write port, read-only substitution from hw_val,
// flattened contents for peripheral logic and a registered per-register write strobe.
module apb3_reg_bank
  import apb3_slave_pkg::*;
#(
  parameter int                DATA_WIDTH = 32,
  parameter int                REG_NUM    = 8,
  parameter int                IDX_W      = 3,
  parameter logic [REG_NUM-1:0] RO_MASK   = '0
) (
  input  logic                          PCLK,
  input  logic                          PRESETn,
  input  logic                          wr_en,
  input  logic [IDX_W-1:0]              wr_idx,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic [IDX_W-1:0]              rd_idx,
  input  logic [REG_NUM*DATA_WIDTH-1:0] hw_val,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic [REG_NUM*DATA_WIDTH-1:0] reg_q,
  output logic [REG_NUM-1:0]            wr_pulse
);

  localparam logic [IDX_W:0] NUM = (IDX_W + 1)'(REG_NUM);

  logic [DATA_WIDTH-1:0] regs   [REG_NUM];
  logic [DATA_WIDTH-1:0] hw_arr [REG_NUM];

  logic wr_ok;
  logic rd_ok;

  assign wr_ok = wr_en && ({1'b0, wr_idx} < NUM);
  assign rd_ok = ({1'b0, rd_idx} < NUM);

  for (genvar i = 0; i < REG_NUM; i++) begin : g_slot
    assign hw_arr[i]                           = hw_val[i*DATA_WIDTH +: DATA_WIDTH];
    assign reg_q[i*DATA_WIDTH +: DATA_WIDTH]   = RO_MASK[i] ? '0 : regs[i];
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
      wr_pulse <= '0;
    end else begin
      wr_pulse <= '0;
      if (wr_ok) begin
        regs[wr_idx]     <= wr_data;
        wr_pulse[wr_idx] <= 1'b1;
      end
    end
  end

  // Read-only slots show the live hardware value instead of storage.
  always_comb begin
    rd_data = '0;
    if (rd_ok) begin
      rd_data = RO_MASK[rd_idx] ? hw_arr[rd_idx] : regs[rd_idx];
    end
  end

endmodule

// File: rtl/apb3_regfile_slave.sv
// APB3 register-file slave: address decode, transfer FSM with wait-state counter,
// and the register bank behind it.
module apb3_regfile_slave
  import apb3_slave_pkg::*;
#(
  parameter int                 ADDR_WIDTH  = 8,
  parameter int                 DATA_WIDTH  = 32,
  parameter int                 REG_NUM     = 8,
  parameter int                 WAIT_CYCLES = 0,
  parameter logic [REG_NUM-1:0] RO_MASK     = '0
) (
  input  logic                          PCLK,
  input  logic                          PRESETn,
  input  logic [ADDR_WIDTH-1:0]         PADDR,
  input  logic                          PSEL,
  input  logic                          PENABLE,
  input  logic                          PWRITE,
  input  logic [DATA_WIDTH-1:0]         PWDATA,
  output logic [DATA_WIDTH-1:0]         PRDATA,
  output logic                          PREADY,
  output logic                          PSLVERR,
  input  logic [REG_NUM*DATA_WIDTH-1:0] hw_val,
  output logic [REG_NUM*DATA_WIDTH-1:0] reg_q,
  output logic [REG_NUM-1:0]            wr_pulse
);

  localparam int INDEX_LSB = calc_index_lsb(DATA_WIDTH);
  localparam int IDX_W     = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
  localparam int CNT_W     = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int CMP_W     = ADDR_WIDTH + 8;

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << INDEX_LSB) - 1);
  localparam logic [CMP_W-1:0]      REG_LIMIT  = CMP_W'(REG_NUM);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > MAX_WAIT) begin : g_bad_wait
    $error("apb3_regfile_slave: WAIT_CYCLES out of range");
  end
  if (DATA_WIDTH != 8 && DATA_WIDTH != 16 && DATA_WIDTH != 32) begin : g_bad_width
    $error("apb3_regfile_slave: DATA_WIDTH must be 8, 16 or 32");
  end
  if (REG_NUM < 1 || REG_NUM > 64) begin : g_bad_num
    $error("apb3_regfile_slave: REG_NUM out of range");
  end

  // Setup-phase decode, only captured in IDLE.
  logic [ADDR_WIDTH-1:0] idx_full;
  logic [IDX_W-1:0]      idx_d;
  logic                  misaligned_d;
  logic                  unmapped_d;
  logic                  ro_err_d;
  logic                  err_d;

  assign idx_full     = PADDR >> INDEX_LSB;
  assign idx_d        = idx_full[IDX_W-1:0];
  assign misaligned_d = |(PADDR & ALIGN_MASK);
  assign unmapped_d   = ({8'd0, idx_full} >= REG_LIMIT);
  assign ro_err_d     = PWRITE && !unmapped_d && RO_MASK[idx_d];
  assign err_d        = misaligned_d || unmapped_d || ro_err_d;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q;
  logic             wr_q;
  logic             err_q;
  logic             setup;
  logic             commit;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (setup) begin
        idx_q <= idx_d;
        wr_q  <= PWRITE;
        err_q <= err_d;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    setup   = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          setup   = 1'b1;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES > 0) ? WAIT : DONE;
        end
      end
      WAIT: begin
        if (!PSEL) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        // A dropped PSEL/PENABLE here is an abort: nothing is committed.
        commit  = PSEL && PENABLE && wr_q && !err_q;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  logic [DATA_WIDTH-1:0] rd_data;

  apb3_reg_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .REG_NUM    (REG_NUM),
    .IDX_W      (IDX_W),
    .RO_MASK    (RO_MASK)
  ) u_bank (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .wr_en    (commit),
    .wr_idx   (idx_q),
    .wr_data  (PWDATA),
    .rd_idx   (idx_q),
    .hw_val   (hw_val),
    .rd_data  (rd_data),
    .reg_q    (reg_q),
    .wr_pulse (wr_pulse)
  );

  // Response is driven from state and latched fields only.
  assign PREADY  = (state_q == DONE);
  assign PSLVERR = (state_q == DONE) && err_q;
  assign PRDATA  = ((state_q == DONE) && !wr_q && !err_q) ? rd_data : '0;

endmodule

// File: tb/tb_apb3_regfile_slave.sv
// Bench for apb3_regfile_slave: two instances (no wait states / three wait states)
// checked every cycle against a register-array model of the slave.
module tb_apb3_regfile_slave;

  localparam int NDUT = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   paddr   [NDUT];
  logic         psel    [NDUT];
  logic         penable [NDUT];
  logic         pwrite  [NDUT];
  logic [31:0]  pwdata  [NDUT];
  logic [31:0]  prdata  [NDUT];
  logic         pready  [NDUT];
  logic         pslverr [NDUT];
  logic [255:0] hw_val  [NDUT];
  logic [255:0] reg_q   [NDUT];
  logic [7:0]   wr_pulse[NDUT];

  // Model state: register contents, expected strobes, pending commits, expected response.
  logic [31:0]  mdl       [NDUT][8];
  logic [7:0]   exp_pulse [NDUT];
  logic         cm_v      [NDUT];
  logic [2:0]   cm_idx    [NDUT];
  logic [31:0]  cm_data   [NDUT];
  logic         exp_ready [NDUT];
  logic         exp_err   [NDUT];
  logic [31:0]  exp_rd    [NDUT];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apb3_regfile_slave #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .REG_NUM(8), .WAIT_CYCLES(0), .RO_MASK(8'h80)
  ) dut0 (
    .PCLK(clk), .PRESETn(rst_n), .PADDR(paddr[0]), .PSEL(psel[0]), .PENABLE(penable[0]),
    .PWRITE(pwrite[0]), .PWDATA(pwdata[0]), .PRDATA(prdata[0]), .PREADY(pready[0]),
    .PSLVERR(pslverr[0]), .hw_val(hw_val[0]), .reg_q(reg_q[0]), .wr_pulse(wr_pulse[0])
  );

  apb3_regfile_slave #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .REG_NUM(8), .WAIT_CYCLES(3), .RO_MASK(8'h80)
  ) dut1 (
    .PCLK(clk), .PRESETn(rst_n), .PADDR(paddr[1]), .PSEL(psel[1]), .PENABLE(penable[1]),
    .PWRITE(pwrite[1]), .PWDATA(pwdata[1]), .PRDATA(prdata[1]), .PREADY(pready[1]),
    .PSLVERR(pslverr[1]), .hw_val(hw_val[1]), .reg_q(reg_q[1]), .wr_pulse(wr_pulse[1])
  );

  // Registers change at the commit edge; the strobe shows in the cycle after.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < NDUT; d++) begin
        for (int i = 0; i < 8; i++) mdl[d][i] <= 32'd0;
        exp_pulse[d] <= 8'd0;
      end
    end else begin
      for (int d = 0; d < NDUT; d++) begin
        exp_pulse[d] <= cm_v[d] ? (8'd1 << cm_idx[d]) : 8'd0;
        if (cm_v[d]) mdl[d][cm_idx[d]] <= cm_data[d];
      end
    end
  end

  function automatic int wc(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic logic [255:0] exp_regq(input int d);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 7; i++) v[i*32 +: 32] = mdl[d][i];
    return v;
  endfunction

  task automatic chk(input string nm, input int d, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t got %h want %h", nm, d, $time, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_exp(input int d);
    exp_ready[d] = 1'b0;
    exp_err[d]   = 1'b0;
    exp_rd[d]    = 32'd0;
  endtask

  // One complete transfer; starts and ends #1 after a rising edge.
  task automatic xfer(input int d, input logic [7:0] a, input logic w, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er);
    logic [5:0]  idx;
    logic        e;
    logic [31:0] rv;
    idx = a[7:2];
    e   = (a[1:0] != 2'b00) || (idx >= 6'd8) || (w && idx == 6'd7);
    rv  = (e || w) ? 32'd0 : ((idx == 6'd7) ? hw_val[d][255:224] : mdl[d][idx[2:0]]);
    rd  = 32'd0;
    er  = 1'b0;
    paddr[d]   = a;
    pwrite[d]  = w;
    pwdata[d]  = $urandom;
    psel[d]    = 1'b1;
    penable[d] = 1'b0;
    clear_exp(d);
    @(posedge clk);
    #1;
    penable[d] = 1'b1;
    paddr[d]   = 8'($urandom);
    pwrite[d]  = 1'($urandom_range(0, 1));
    for (int k = 1; k <= wc(d) + 1; k++) begin
      pwdata[d] = $urandom;
      if (k == wc(d) + 1) begin
        exp_ready[d] = 1'b1;
        exp_err[d]   = e;
        exp_rd[d]    = rv;
        pwdata[d]    = wd;
        cm_v[d]      = w && !e;
        cm_idx[d]    = idx[2:0];
        cm_data[d]   = wd;
        rd           = prdata[d];
        er           = pslverr[d];
      end
      @(posedge clk);
      #1;
    end
    cm_v[d]    = 1'b0;
    psel[d]    = 1'b0;
    penable[d] = 1'b0;
    clear_exp(d);
  endtask

  // Transfer abandoned by dropping PSEL after `keep` wait cycles.
  task automatic abort_xfer(input int d, input logic [7:0] a, input int keep);
    paddr[d]   = a;
    pwrite[d]  = 1'b1;
    pwdata[d]  = $urandom;
    psel[d]    = 1'b1;
    penable[d] = 1'b0;
    clear_exp(d);
    @(posedge clk);
    #1;
    penable[d] = 1'b1;
    repeat (keep) begin
      @(posedge clk);
      #1;
    end
    psel[d]    = 1'b0;
    penable[d] = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [7:0]  a;
    logic        w;
    int          r;

    rst_n = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      paddr[d] = 8'd0; psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0; pwdata[d] = 32'd0;
      hw_val[d] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      hw_val[d][255:224] = 32'h12345678;
      cm_v[d] = 1'b0; cm_idx[d] = 3'd0; cm_data[d] = 32'd0;
      clear_exp(d);
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk("reset_pready", d, 256'(pready[d]), 256'(0));
      chk("reset_regq", d, reg_q[d], 256'(0));
      chk("reset_pulse", d, 256'(wr_pulse[d]), 256'(0));
    end

    fork
      forever begin
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
          chk("pready", d, 256'(pready[d]), 256'(exp_ready[d]));
          chk("pslverr", d, 256'(pslverr[d]), 256'(exp_err[d]));
          chk("prdata", d, 256'(prdata[d]), 256'(exp_rd[d]));
          chk("reg_q", d, reg_q[d], exp_regq(d));
          chk("wr_pulse", d, 256'(wr_pulse[d]), 256'(exp_pulse[d]));
        end
      end
    join_none

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);

    xfer(0, 8'h04, 1'b0, 32'd0, rd, er);
    chk("first_read_data", 0, 256'(rd), 256'(0));
    chk("first_read_err", 0, 256'(er), 256'(0));

    xfer(0, 8'h08, 1'b1, 32'hDEADBEEF, rd, er);
    chk("write_pulse", 0, 256'(wr_pulse[0]), 256'(8'b0000_0100));
    chk("write_slot2", 0, 256'(reg_q[0][95:64]), 256'(32'hDEADBEEF));
    xfer(0, 8'h08, 1'b0, 32'd0, rd, er);
    chk("readback", 0, 256'(rd), 256'(32'hDEADBEEF));
    chk("pulse_gone", 0, 256'(wr_pulse[0]), 256'(0));

    xfer(1, 8'h00, 1'b0, 32'd0, rd, er);
    chk("wait_read_data", 1, 256'(rd), 256'(0));

    for (int d = 0; d < NDUT; d++) begin
      xfer(d, 8'h1C, 1'b1, 32'hFFFF0000, rd, er);
      chk("ro_write_err", d, 256'(er), 256'(1));
      xfer(d, 8'h1C, 1'b0, 32'd0, rd, er);
      chk("ro_read_data", d, 256'(rd), 256'(32'h12345678));
      chk("ro_read_err", d, 256'(er), 256'(0));
      xfer(d, 8'h20, 1'b1, 32'h11111111, rd, er);
      chk("unmapped_err", d, 256'(er), 256'(1));
      xfer(d, 8'h06, 1'b1, 32'h22222222, rd, er);
      chk("misaligned_err", d, 256'(er), 256'(1));
      idle(1);
    end

    xfer(1, 8'h00, 1'b1, 32'hA5A5A5A5, rd, er);
    xfer(1, 8'h04, 1'b1, 32'h5A5A5A5A, rd, er);
    xfer(1, 8'h00, 1'b0, 32'd0, rd, er);
    chk("b2b_first", 1, 256'(rd), 256'(32'hA5A5A5A5));
    xfer(1, 8'h04, 1'b0, 32'd0, rd, er);
    chk("b2b_second", 1, 256'(rd), 256'(32'h5A5A5A5A));

    abort_xfer(1, 8'h0C, 1);
    abort_xfer(1, 8'h10, 2);
    xfer(1, 8'h0C, 1'b0, 32'd0, rd, er);
    chk("abort_no_commit", 1, 256'(rd), 256'(0));

    // Reset lands while dut1 sits in wait states.
    paddr[1] = 8'h14; pwrite[1] = 1'b1; pwdata[1] = 32'h0BADF00D;
    psel[1] = 1'b1; penable[1] = 1'b0;
    @(posedge clk);
    #1;
    penable[1] = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    psel[1] = 1'b0;
    penable[1] = 1'b0;
    #1;
    chk("rst_mid_pready", 1, 256'(pready[1]), 256'(0));
    chk("rst_mid_regq1", 1, reg_q[1], 256'(0));
    chk("rst_mid_regq0", 0, reg_q[0], 256'(0));
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle(1);
    xfer(1, 8'h14, 1'b1, 32'h0BADF00D, rd, er);
    xfer(1, 8'h14, 1'b0, 32'd0, rd, er);
    chk("after_reset_read", 1, 256'(rd), 256'(32'h0BADF00D));

    for (int d = 0; d < NDUT; d++) begin
      for (int n = 0; n < 150; n++) begin
        r = int'($urandom_range(0, 9));
        if (r < 6)      a = 8'($urandom_range(0, 7) * 4);
        else if (r < 8) a = 8'($urandom_range(0, 255));
        else            a = 8'($urandom_range(8, 63) * 4);
        if (r == 9) hw_val[d][255:224] = $urandom;
        w = 1'($urandom_range(0, 1));
        xfer(d, a, w, $urandom, rd, er);
        if ($urandom_range(0, 3) > 1) idle(int'($urandom_range(1, 2)));
      end
    end

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb3_regfile_slave.md
# apb3_regfile_slave

Parametrised APB3 register-file slave. It offers REG_NUM word-aligned registers, read-only register masking, and a configurable number of wait states. PSLVERR is raised for unmapped, misaligned or read-only-write accesses. It sits behind the APB bridge/decoder and exposes register contents and per-register write strobes to peripheral logic.

## Interface
- ADDR_WIDTH, 8, PADDR width; must be ≥ $clog2(REG_NUM)+INDEX_LSB.
- DATA_WIDTH, 32, bus and register width; allowed values 8, 16, 32.
- REG_NUM, 8, number of registers; 1..64.
- WAIT_CYCLES, 0, wait states inserted before PREADY; 0..15.
- RO_MASK, '0, REG_NUM bits; bit i=1 makes register i read-only, with its value taken from hw_val.
- PCLK  in  1  APB clock; all logic on rising edge.
- PRESETn  in  1  reset, asynchronous, active-low.
- PADDR  in  ADDR_WIDTH  byte address.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1=write, 0=read.
- PWDATA  in  DATA_WIDTH  write data.
- PRDATA  out  DATA_WIDTH  read data; valid only when PREADY=1, else 0.
- PREADY  out  1  transfer completion.
- PSLVERR  out  1  error; valid only when PREADY=1, else 0.
- hw_val  in  REG_NUM*DATA_WIDTH  read values for RO registers; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- reg_q  out  REG_NUM*DATA_WIDTH  current RW register contents; RO slots read 0.
- wr_pulse  out  REG_NUM  one-cycle strobe, registered, asserted the cycle after a committed write to register i.

## Operation
- Address decode:
  - INDEX_LSB = $clog2(DATA_WIDTH/8).
  - index = PADDR >> INDEX_LSB.
  - misaligned = PADDR[INDEX_LSB-1:0] != 0, only when INDEX_LSB > 0.
  - unmapped = index ≥ REG_NUM.
  - ro_err = PWRITE && RO_MASK[index].
  - err = misaligned | unmapped | ro_err.
- FSM states are IDLE, WAIT and DONE.
- IDLE:
  - A setup phase (PSEL=1, PENABLE=0) sampled at the edge latches index, PWRITE and err, and loads cnt=WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, else DONE.
- WAIT:
  - cnt decrements each cycle; at cnt==1 next state is DONE.
  - PREADY=0 throughout.
- DONE:
  - PREADY=1 and PSLVERR=latched err.
  - Read without error: PRDATA = RO ? hw_val slice : register. The mux is combinational from latched index, so hw_val is sampled live in this cycle.
  - Write without error: register[index] <= PWDATA at the closing edge; wr_pulse[index]=1 in the following cycle.
  - On error: no register change, PRDATA=0.
  - Next state is IDLE.
- Abort: PSEL=0 in WAIT or DONE, or PENABLE=0 in DONE, returns the FSM to IDLE next cycle with no commit and no error.
- Back-to-back transfers: DONE → IDLE. The following setup phase is accepted in IDLE, so each transfer occupies 2+WAIT_CYCLES bus cycles with no dead cycle.
- Signals ignored outside their valid phase: PADDR/PWRITE changes after the setup edge, and PWDATA outside the DONE cycle.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state=IDLE, cnt=0, all registers=0.
  - PREADY=0, PSLVERR=0, PRDATA=0, wr_pulse=0.
- Reset asserted mid-transfer: FSM returns to IDLE immediately, no write, outputs take reset values in the same cycle.
- PREADY, PSLVERR and PRDATA decode from state/latched values only, with no combinational path from PADDR.
- Latency:
  - Setup edge → PREADY high after WAIT_CYCLES+1 edges.
  - Write commit → reg_q update at the same edge; wr_pulse one cycle later.
- cnt width = max(1, $clog2(WAIT_CYCLES+1)), unsigned, no wrap (it stops at 0).

## Structure
- Package apb3_slave_pkg holds:
  - state_t enum {IDLE, WAIT, DONE}, 2 bits.
  - function calc_index_lsb(data_width).
  - localparam MAX_WAIT=15.
- Sub-module apb3_reg_bank holds the storage array, write port (en, index, data), RO mux to hw_val, reg_q flattening and wr_pulse register.
- Top level holds the FSM, counter and decode.

## Test plan
- Reset then read: DATA_WIDTH=32, WAIT_CYCLES=0; read 0x04 → PREADY in 2nd cycle, PRDATA=0x0, PSLVERR=0.
- RW write/read: write 0xDEADBEEF to 0x08, read 0x08 → PRDATA=0xDEADBEEF, reg_q slot 2 updated, wr_pulse=8'b0000_0100 for exactly one cycle.
- Wait states: WAIT_CYCLES=3; read 0x00 → PREADY low for 3 access cycles, high on the 4th; transfer spans 5 cycles total.
- Errors, REG_NUM=8, RO_MASK=8'h80, hw_val slot 7=0x12345678:
  - Write 0x1C → PSLVERR=1, reg unchanged, no wr_pulse.
  - Read 0x1C → PRDATA=0x12345678, PSLVERR=0.
  - Write 0x20 (unmapped) or 0x06 (misaligned) → PSLVERR=1, no state change.
- Back-to-back plus abort:
  - Two consecutive writes with no idle cycle → both committed.
  - PSEL dropped during WAIT (WAIT_CYCLES=2) → no commit, FSM in IDLE next cycle.
- Reset mid-transfer: PRESETn low during WAIT → PREADY=0 immediately, all registers 0, next transfer completes normally.
